dft_frame_loader: RTL and testbench
===================================

# dft_frame_loader

Serial-to-parallel framing stage directly upstream of the 32-point DFT `top`. It accepts one real N-bit sample per handshake and assembles 32 consecutive samples into a frame. The completed frame is presented on a flattened bus that drives `in0_r`..`in31_r`. A ping-pong pair of banks lets the next frame load while the DFT consumes the current one.

## Interface
- `N`, 16: sample width, two's complement; matches DFT `N`
- `FRAME`, 32: samples per frame; fixed to the DFT size, power of two
- `clk2`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  loader can accept a sample
- `s_data`  in  N  input sample
- `s_sof`  in  1  start of frame, qualified by `s_valid & s_ready`
- `frame_valid`  out  1  complete frame on `frame_data`
- `frame_ready`  in  1  DFT accepts the frame
- `frame_data`  out  FRAME*N  sample k occupies bits [k*N +: N]; k=0 is the oldest sample
- `frame_abort`  out  1  one-cycle pulse when a partial frame is discarded
- `frame_cnt`  out  16  delivered-frame count; present only with `DFT_LOADER_FRAME_CNT_EN`

## Operation
- Two banks, each FRAME×N. One is the write bank (`wr_sel`) and the other is the read bank.
- Write side counter `wr_idx` runs 0..FRAME-1. Write-side states:
  - FILL: the write bank is accepting samples.
  - FULL: the write bank is complete but cannot yet swap.
- Read side states:
  - EMPTY: no frame is presented.
  - VALID: a frame is presented.
- An accept is `s_valid & s_ready`. It writes `s_data` to `bank[wr_sel][wr_idx]` and increments `wr_idx`.
- An accept with `s_sof=1` writes to index 0 and sets `wr_idx` to 1.
  - If `wr_idx` was nonzero, the partial frame is discarded and `frame_abort` pulses on the next cycle.
  - `s_sof` on the sample at index 0 is legal and silent.
- When the last sample (idx FRAME-1) is accepted:
  - If the read side is EMPTY, or the read side is VALID with `frame_ready=1` in the same cycle, the banks swap. `wr_sel` toggles, the read side goes VALID, `wr_idx` returns to 0 and the write side stays FILL.
  - Otherwise the write side enters FULL.
- FULL with a read-side handshake (`frame_valid & frame_ready`): the banks swap and the read side stays VALID with the new frame. The write side returns to FILL with `wr_idx=0`.
- VALID with a handshake and no pending swap: the read side goes EMPTY.
- `s_ready` = (write state == FILL). It is a registered-state decode and has no combinational path from `frame_ready`.
- While `frame_valid=1`, `frame_data` is stable until the handshake. The read bank is never written.
- Arithmetic: samples are stored unmodified. There is no scaling, sign extension or rounding.

## Timing
- Reset values: `s_ready=1`, `frame_valid=0`, `frame_abort=0`, `frame_cnt=0`, `wr_idx=0`, `wr_sel=0`.
  - `frame_data` is all-zero at reset (both banks cleared).
- Latency: the last sample is accepted at edge t; `frame_valid=1` after edge t, i.e. in cycle t+1.
- Throughput: one sample per cycle sustained when `frame_ready` is held at 1. Frames are back-to-back with no bubble on `s_ready`.
- Backpressure:
  - With the read side VALID and unconsumed, the loader absorbs one further full frame.
  - `s_ready` falls in the cycle after the 64th buffered sample is accepted.
  - `s_ready` rises the cycle after the `frame_ready` handshake.
- `frame_abort` is high for exactly one cycle, in the cycle after the aborting accept.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any partial or presented frame is lost and no `frame_abort` is generated.
- `s_sof` without `s_valid`, or while `s_ready=0`, is ignored.

## Configuration
- `DFT_LOADER_FRAME_CNT_EN` defined:
  - Adds the `frame_cnt` port.
  - The counter increments on each `frame_valid & frame_ready` handshake and wraps 0xFFFF→0.
  - Aborted frames are not counted.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `dft_pkg`:
  - `DFT_N=16`
  - `DFT_FRAME=32`
  - `IDX_W=$clog2(DFT_FRAME)`
  - enum `wr_state_t` {FILL, FULL}
  - enum `rd_state_t` {EMPTY, VALID}
- One sub-module, `dft_pingpong_bank`. It holds both banks with a write port (sel, idx, data, we) and a full-width read of the non-selected bank.
- The loader top holds `wr_idx`, both state registers, the abort pulse and the optional counter.

## Test plan
- Reset then ramp: feed 32 samples 2,2,2,2,3,…,9,9 (each value ×4) with `frame_ready=1`.
  - Expect `frame_valid` in the cycle after the 32nd accept.
  - Expect `frame_data[0 +: 16]=2` and `[31*16 +: 16]=9`.
  - Expect `frame_cnt=1` after the handshake.
- Continuous stream of 96 samples 0..95 with `frame_ready=1`: expect `s_ready` constantly 1 and three frames.
  - Frame 0 element 0 = 0; frame 1 element 0 = 32; frame 2 element 31 = 95.
- `frame_ready=0`, stream 70 samples:
  - Expect 64 accepts and `s_ready=0` from the cycle after accept 64.
  - `frame_data` is held at frame 0.
  - Raise `frame_ready` for 1 cycle: frame 1 is presented with element 0 = 32, `s_ready=1`, and the remaining 6 samples accepted.
- Abort: 10 samples, then an accept with `s_sof=1` and data 0x7FFF.
  - Expect one `frame_abort` pulse and the next frame element 0 = 0x7FFF.
  - `frame_cnt` does not increment for the aborted frame.
- Async reset asserted at sample 20 of frame 2 with a frame VALID:
  - Outputs go to reset values without waiting for a clock edge.
  - A following 32-sample frame is delivered correctly.
- Negative data 0x8000 and 0xFFFF at indices 0 and 31: expect them reproduced bit-exactly in `frame_data`.

Source files
------------

// File: rtl/dft_pkg.sv
// rtl/dft_pkg.sv - shared constants and state types for the DFT frame loader
//
// Purpose: sample width, frame size, index width and the write/read side
// state encodings used by dft_frame_loader and dft_pingpong_bank.
package dft_pkg;

  localparam int DFT_N     = 16;
  localparam int DFT_FRAME = 32;
  localparam int IDX_W     = $clog2(DFT_FRAME);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } rd_state_t;

endpackage

// File: rtl/dft_pingpong_bank.sv
// rtl/dft_pingpong_bank.sv - two FRAME x N sample banks, one written, one read
//
// Purpose: storage for the frame loader. The bank selected by wr_sel takes
// single-sample writes; the other bank is presented full-width on rd_data.
// Ports:
//   clk2     in   clock, rising edge
//   rst      in   asynchronous active-low reset, clears both banks
//   wr_sel   in   bank being written (rd_data shows the other bank)
//   wr_idx   in   sample index within the write bank
//   wr_data  in   sample to store
//   we       in   write enable
//   rd_data  out  read bank, sample k at [k*N +: N]
module dft_pingpong_bank
  import dft_pkg::*;
#(
  parameter int N     = DFT_N,
  parameter int FRAME = DFT_FRAME
) (
  input  logic                       clk2,
  input  logic                       rst,
  input  logic                       wr_sel,
  input  logic [$clog2(FRAME)-1:0]   wr_idx,
  input  logic [N-1:0]               wr_data,
  input  logic                       we,
  output logic [FRAME*N-1:0]         rd_data
);

  logic [N-1:0] mem [2][FRAME];

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < FRAME; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else if (we) begin
      mem[wr_sel][wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < FRAME; k++) begin
      rd_data[k*N +: N] = mem[~wr_sel][k];
    end
  end

endmodule

// File: rtl/dft_frame_loader.sv
// rtl/dft_frame_loader.sv - serial-to-parallel ping-pong frame assembler for the 32-point DFT
//
// Purpose: accepts one N-bit sample per s_valid/s_ready handshake, assembles
// FRAME samples into a bank and presents the completed frame on frame_data
// while the next frame loads into the other bank.
// Optional feature macro: DFT_LOADER_FRAME_CNT_EN adds the frame_cnt port.
// Ports:
//   clk2         in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   s_valid      in   sample valid
//   s_ready      out  loader can accept a sample
//   s_data       in   sample
//   s_sof        in   start of frame, qualified by the accept
//   frame_valid  out  complete frame presented
//   frame_ready  in   consumer accepts the frame
//   frame_data   out  frame, sample k at [k*N +: N], k=0 oldest
//   frame_abort  out  one-cycle pulse after a partial frame is discarded
//   frame_cnt    out  delivered-frame count (DFT_LOADER_FRAME_CNT_EN only)
module dft_frame_loader
  import dft_pkg::*;
#(
  parameter int N     = DFT_N,
  parameter int FRAME = DFT_FRAME
) (
  input  logic               clk2,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N-1:0]       s_data,
  input  logic               s_sof,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME*N-1:0] frame_data,
  output logic               frame_abort
`ifdef DFT_LOADER_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int             IW       = $clog2(FRAME);
  localparam logic [IW-1:0]  LAST_IDX = IW'(FRAME - 1);

  wr_state_t     wr_state;
  rd_state_t     rd_state;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] wr_addr;
  logic          wr_sel;
  logic          abort_q;
  logic          accept;
  logic          handshake;
  logic          last;
  logic          swap_on_fill;
  logic          swap_on_full;

  assign s_ready     = (wr_state == FILL);
  assign frame_valid = (rd_state == VALID);
  assign frame_abort = abort_q;

  assign accept    = s_valid & s_ready;
  assign handshake = frame_valid & frame_ready;
  // A start-of-frame sample always lands at index 0, restarting the frame.
  assign wr_addr   = s_sof ? '0 : wr_idx;
  assign last      = accept && (wr_addr == LAST_IDX);

  // Completing a frame swaps immediately if the read side is free (or being
  // freed this cycle); otherwise the completed bank waits in FULL.
  assign swap_on_fill = last && ((rd_state == EMPTY) || handshake);
  assign swap_on_full = (wr_state == FULL) && handshake;

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      wr_state <= FILL;
      rd_state <= EMPTY;
      wr_idx   <= '0;
      wr_sel   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= accept && s_sof && (wr_idx != '0);

      if (accept) begin
        wr_idx <= last ? '0 : wr_addr + 1'b1;
      end

      if (swap_on_fill || swap_on_full) begin
        wr_sel <= ~wr_sel;
      end

      if (last && !swap_on_fill) begin
        wr_state <= FULL;
      end else if (swap_on_full) begin
        wr_state <= FILL;
      end

      // A FULL swap replaces the presented frame, so the read side stays VALID.
      if (swap_on_fill) begin
        rd_state <= VALID;
      end else if (handshake && !swap_on_full) begin
        rd_state <= EMPTY;
      end
    end
  end

`ifdef DFT_LOADER_FRAME_CNT_EN
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (handshake) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  dft_pingpong_bank #(
    .N     (N),
    .FRAME (FRAME)
  ) u_bank (
    .clk2    (clk2),
    .rst     (rst),
    .wr_sel  (wr_sel),
    .wr_idx  (wr_addr),
    .wr_data (s_data),
    .we      (accept),
    .rd_data (frame_data)
  );

endmodule

// File: tb/tb_dft_frame_loader.sv
// tb/tb_dft_frame_loader.sv - self-checking bench for dft_frame_loader
module tb_dft_frame_loader;

  typedef logic [32*16-1:0] frame_t;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d31;
    logic [15:0] e0;
    logic [15:0] e31;
  } vec_t;

  logic         clk2 = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  s_data = '0;
  logic         s_sof = 1'b0;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  frame_t       frame_data;
  logic         frame_abort;
`ifdef DFT_LOADER_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  dft_frame_loader dut (
    .clk2        (clk2),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_abort (frame_abort)
`ifdef DFT_LOADER_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk2 = ~clk2;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a list of samples collected so far and a list of
  // completed frames waiting to be delivered (front one is presented).
  logic [15:0] part[$];
  frame_t      pend[$];
  frame_t      got[$];
  logic        m_abort = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        last_acc;
  int          ab_seen;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    part.delete();
    pend.delete();
    m_abort = 1'b0;
    m_cnt = '0;
  endtask

  // One clock: compare registered outputs to the model, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic sof, input logic fr);
    logic   acc, hs;
    frame_t f;
    chk("s_ready", s_ready, pend.size() < 2);
    chk("frame_valid", frame_valid, pend.size() > 0);
    chk("frame_abort", frame_abort, m_abort);
    if (pend.size() > 0) chk("frame_data", frame_data, pend[0]);
`ifdef DFT_LOADER_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, m_cnt);
`endif
    if (frame_abort) ab_seen++;
    s_valid = v; s_data = d; s_sof = sof; frame_ready = fr;
    acc = v && (pend.size() < 2);
    hs  = (pend.size() > 0) && fr;
    m_abort = acc && sof && (part.size() > 0);
    if (hs) begin
      got.push_back(frame_data);
      void'(pend.pop_front());
      m_cnt++;
    end
    if (acc) begin
      if (sof) part.delete();
      part.push_back(d);
      if (part.size() == 32) begin
        for (int k = 0; k < 32; k++) f[k*16 +: 16] = part[k];
        pend.push_back(f);
        part.delete();
      end
    end
    last_acc = acc;
    @(posedge clk2);
    @(negedge clk2);
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    s_valid = 0; s_sof = 0; frame_ready = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_abort", frame_abort, 0);
    chk("rst_frame_data", frame_data, 0);
`ifdef DFT_LOADER_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    @(posedge clk2);
    @(negedge clk2);
    rst = 1'b1;
    model_clear();
  endtask

  vec_t   vecs[4];
  frame_t tmp;
  int     sent, low;

  initial begin
    vecs[0] = '{16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF};
    vecs[1] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000};
    vecs[2] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001};
    vecs[3] = '{16'h0000, 16'h8001, 16'h0000, 16'h8001};

    @(negedge clk2);
    do_reset();

    // Ramp 2,2,2,2,3,...,9
    for (int i = 0; i < 32; i++) cycle(1, 16'(2 + i / 4), 0, 1);
    chk("ramp_valid", frame_valid, 1);
    tmp = frame_data;
    chk("ramp_elem0", tmp[15:0], 2);
    chk("ramp_elem31", tmp[511:496], 9);
    cycle(0, 0, 0, 1);
`ifdef DFT_LOADER_FRAME_CNT_EN
    chk("ramp_cnt", frame_cnt, 1);
`endif

    // Continuous 96 samples
    do_reset();
    got.delete();
    low = 0;
    for (int i = 0; i < 96; i++) begin
      if (!s_ready) low++;
      cycle(1, 16'(i), 0, 1);
    end
    cycle(0, 0, 0, 1);
    chk("cont_bubbles", low, 0);
    chk("cont_frames", got.size(), 3);
    if (got.size() == 3) begin
      tmp = got[0]; chk("cont_f0_e0", tmp[15:0], 0);
      tmp = got[1]; chk("cont_f1_e0", tmp[15:0], 32);
      tmp = got[2]; chk("cont_f2_e31", tmp[511:496], 95);
    end

    // Backpressure
    do_reset();
    sent = 0; low = 0;
    for (int c = 0; c < 70; c++) begin
      if (!s_ready) low++;
      cycle(1, 16'(sent), 0, 0);
      if (last_acc) sent++;
    end
    chk("bp_accepts", sent, 64);
    chk("bp_low_cycles", low, 6);
    chk("bp_ready_low", s_ready, 0);
    tmp = frame_data;
    chk("bp_held_e0", tmp[15:0], 0);
    chk("bp_held_e31", tmp[511:496], 31);
    cycle(1, 16'(sent), 0, 1);
    if (last_acc) sent++;
    chk("bp_swap_valid", frame_valid, 1);
    tmp = frame_data;
    chk("bp_swap_e0", tmp[15:0], 32);
    chk("bp_swap_ready", s_ready, 1);
    for (int c = 0; c < 20 && sent < 70; c++) begin
      cycle(1, 16'(sent), 0, 0);
      if (last_acc) sent++;
    end
    chk("bp_rest_accepted", sent, 70);

    // Abort
    do_reset();
    got.delete();
    ab_seen = 0;
    for (int i = 0; i < 10; i++) cycle(1, 16'(100 + i), 0, 1);
    cycle(1, 16'h7FFF, 1, 1);
    chk("abort_pulse", frame_abort, 1);
    for (int i = 1; i < 32; i++) cycle(1, 16'(200 + i), 0, 1);
    cycle(0, 0, 0, 1);
    chk("abort_count", ab_seen, 1);
    chk("abort_frames", got.size(), 1);
    if (got.size() == 1) begin
      tmp = got[0];
      chk("abort_e0", tmp[15:0], 16'h7FFF);
      chk("abort_e31", tmp[511:496], 231);
    end
`ifdef DFT_LOADER_FRAME_CNT_EN
    chk("abort_cnt", frame_cnt, 1);
`endif

    // Async reset mid-frame with a frame presented
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1, 16'(i), 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 16'(64 + i), 0, 0);
    chk("pre_reset_valid", frame_valid, 1);
    do_reset();
    got.delete();
    for (int i = 0; i < 32; i++) cycle(1, 16'(500 + i), 0, 1);
    cycle(0, 0, 0, 1);
    chk("post_reset_frames", got.size(), 1);
    if (got.size() == 1) begin
      tmp = got[0];
      chk("post_reset_e0", tmp[15:0], 500);
      chk("post_reset_e31", tmp[511:496], 531);
    end

    // Table: bit-exact extreme values at indices 0 and 31
    for (int t = 0; t < 4; t++) begin
      got.delete();
      for (int i = 0; i < 32; i++)
        cycle(1, (i == 0) ? vecs[t].d0 : (i == 31) ? vecs[t].d31 : 16'(i), 0, 1);
      cycle(0, 0, 0, 1);
      chk("vec_frames", got.size(), 1);
      if (got.size() == 1) begin
        tmp = got[0];
        chk("vec_e0", tmp[15:0], vecs[t].e0);
        chk("vec_e31", tmp[511:496], vecs[t].e31);
      end
    end

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++)
      cycle($urandom_range(0, 4) != 0, 16'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
